muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the execute stage. It takes the same forwarded operand pair the ALU receives and computes MULT, MULTU, DIV or DIVU over several cycles. Results land in architectural HI/LO registers, which MFHI/MFLO read. While an operation is in flight the unit holds `busy`, and the hazard logic stalls on it; all other instructions take the single-cycle ALU path.

## Interface
- `N`, default 32: operand and HI/LO width; must be even and ≥ 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only when `busy` = 0.
- `op`  in  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `x`  in  N  operand rs (multiplicand or dividend); sampled with `start`.
- `y`  in  N  operand rt (multiplier or divisor); sampled with `start`.
- `wr_hi`, `wr_lo`  in  1 each  MTHI/MTLO write enables; honoured only when `busy` = 0.
- `wdata`  in  N  data for MTHI/MTLO.
- `busy`  out  1  operation in progress; stall request to the hazard unit.
- `done`  out  1  one-cycle pulse: HI/LO have just been updated by an operation.
- `hi`, `lo`  out  N each  architectural HI/LO registers.

## Operation
- Clock is `clk`. Reset `rst` is asynchronous and active-high. Reset clears `busy`, `done`, `hi`, `lo` and all internal registers to 0, with state IDLE.
- Datapath is one shared engine:
  - an N-bit accumulator/remainder register,
  - an N-bit shift register holding the multiplier, or the dividend turning into the quotient,
  - an N-bit operand register holding the multiplicand or divisor,
  - a log2(N)+1-bit iteration counter,
  - a 2-bit result-sign register: product/quotient sign and remainder sign.
- Signed ops (MULT, DIV) take magnitudes on entry: a negative operand is two's-complement negated.
  - Product sign = x[N-1] ^ y[N-1].
  - Quotient sign = x[N-1] ^ y[N-1].
  - Remainder sign = x[N-1].
  - Unsigned ops clear both sign bits.
- Multiply uses shift-add, one multiplier bit per cycle, LSB first. The adder is N+1 bits wide, so the carry is kept. After N iterations {acc, shreg} holds the 2N-bit magnitude product.
- Divide uses a restoring algorithm, one quotient bit per cycle, MSB first. The subtractor is N+1 bits wide. After N iterations shreg holds the quotient and acc holds the remainder.
- FIX step:
  - Multiply: if the sign bit is set, negate the 2N-bit product. Write hi = upper N bits, lo = lower N bits.
  - Divide: negate quotient and remainder independently per their sign bits. Write lo = quotient, hi = remainder.
- Divide by zero: no trap. The result is defined as lo = all ones, hi = x as sampled (the raw dividend). This applies to both signed and unsigned divide.
- Signed overflow case, x = most negative value and y = −1: lo = x, hi = 0. This falls out of the magnitude math and needs no special case.
- `start` while `busy` = 1 is ignored. `op`, `x` and `y` are don't-care when `start` = 0.
- MTHI/MTLO behaviour:
  - With `busy` = 0, `wr_hi`/`wr_lo` load `wdata` into hi/lo at the edge.
  - While `busy` = 1 they are ignored.
  - If `start` and a write arrive in the same idle cycle, the write takes effect, and the operation's result overwrites both registers at FIX.

## Timing
- States are IDLE → RUN → FIX → IDLE. `busy` = (state ≠ IDLE), registered.
- Edge E0: `start` = 1 and IDLE. Operands and magnitudes are loaded, counter = 0, and state goes to RUN.
- Edges E1…EN: one iteration each. At EN the counter reaches N−1 and state goes to FIX.
- Edge E(N+1): hi/lo are written, state goes to IDLE, and `done` = 1 for exactly the cycle after E(N+1).
- `busy` is high for N+1 cycles, and hi/lo change only at E(N+1).
- For N = 32, results are visible 33 cycles after the start edge.
- A new `start` is accepted in the cycle `done` is high, giving back-to-back operations with no bubble.
- hi/lo hold their values between operations. MFHI/MFLO reads are combinational from the registers.
- `rst` asserted mid-operation aborts immediately. All outputs return to their reset values, and no partial result reaches hi/lo.

## Test plan
- Reset, then MULTU with x = 0xFFFFFFFF, y = 0xFFFFFFFF → `busy` high for 33 cycles, `done` pulse; hi = 0xFFFFFFFE, lo = 0x00000001.
- MULT with x = −7 (0xFFFFFFF9), y = 6 → hi = 0xFFFFFFFF, lo = 0xFFFFFFD6. Then, back-to-back in the `done` cycle, MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- DIV tests:
  - x = −7, y = 2 → lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1).
  - DIVU x = 7, y = 2 → lo = 3, hi = 1.
  - DIV x = 0x80000000, y = 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- Divide by zero: DIVU x = 0x1234, y = 0 → lo = 0xFFFFFFFF, hi = 0x1234. Same result for DIV.
- Busy interlock:
  - Start MULTU 3 × 5. At cycle 10 pulse `start` with other operands, and pulse `wr_hi` with wdata = 0xAAAA. Both are ignored; the final hi = 0, lo = 15.
  - When idle, `wr_lo` with 0x55 sets lo = 0x55 the next cycle.
- Reset mid-operation: assert `rst` asynchronously at cycle 12 of DIVU 100/7 → `busy`, `done`, hi and lo go to 0 immediately. After release, DIVU 100/7 completes with lo = 14, hi = 2.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO.
// Shift-add multiply and restoring divide share one datapath.
module muldiv_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         wr_hi,
   input  logic         wr_lo,
   input  logic [N-1:0] wdata,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo
);

   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic [N-1:0]   acc;
   logic [N-1:0]   shreg;
   logic [N-1:0]   opnd;
   logic [CW-1:0]  cnt;
   logic [1:0]     sgn;
   logic           is_div;

   logic           sop;
   logic           xneg;
   logic           yneg;
   logic           yzero;
   logic [N-1:0]   xmag;
   logic [N-1:0]   ymag;

   logic [N:0]     madd;
   logic [N:0]     rem;
   logic [N-1:0]   dsub;
   logic           ge;

   logic [2*N-1:0] prod;
   logic [N-1:0]   quo;
   logic [N-1:0]   rmd;
   logic           last;

   // Magnitudes on entry; op[0]=0 selects the signed flavours
   assign sop   = ~op[0];
   assign xneg  = sop & x[N-1];
   assign yneg  = sop & y[N-1];
   assign yzero = (y == '0);
   assign xmag  = xneg ? ('0 - x) : x;
   assign ymag  = yneg ? ('0 - y) : y;

   // Shift-add step: N+1 bit sum keeps the carry
   assign madd = shreg[0] ? ({1'b0, acc} + {1'b0, opnd})
                          : {1'b0, acc};

   // Restoring step: shift in next dividend bit, try subtract.
   // When ge holds the true difference is below opnd, so the low
   // N bits of the modular subtraction are exact.
   assign rem  = {acc, shreg[N-1]};
   assign ge   = (rem >= {1'b0, opnd});
   assign dsub = rem[N-1:0] - opnd;

   // Sign fix-up of the finished magnitudes
   assign prod = sgn[1] ? ('0 - {acc, shreg}) : {acc, shreg};
   assign quo  = sgn[1] ? ('0 - shreg) : shreg;
   assign rmd  = sgn[0] ? ('0 - acc) : acc;

   assign last = (cnt == CW'(N - 1));

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = RUN;
         RUN:  if (last) state_nx = FIX;
         FIX:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register and registered busy flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx != IDLE);
      end
   end

   // Datapath, HI/LO and done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         shreg  <= '0;
         opnd   <= '0;
         cnt    <= '0;
         sgn    <= '0;
         is_div <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (wr_hi) hi <= wdata;
               if (wr_lo) lo <= wdata;
               if (start) begin
                  is_div <= op[1];
                  acc    <= '0;
                  cnt    <= '0;
                  // Divide by zero keeps an all-ones quotient
                  sgn[1] <= (xneg ^ yneg) & ~(op[1] & yzero);
                  sgn[0] <= op[1] & xneg;
                  if (op[1]) begin
                     shreg <= xmag;
                     opnd  <= ymag;
                  end else begin
                     shreg <= ymag;
                     opnd  <= xmag;
                  end
               end
            end
            RUN: begin
               if (!last) cnt <= cnt + 1'b1;
               if (is_div) begin
                  acc   <= ge ? dsub : rem[N-1:0];
                  shreg <= {shreg[N-2:0], ge};
               end else begin
                  acc   <= madd[N:1];
                  shreg <= {madd[0], shreg[N-1:1]};
               end
            end
            FIX: begin
               done <= 1'b1;
               if (is_div) begin
                  lo <= quo;
                  hi <= rmd;
               end else begin
                  hi <= prod[2*N-1:N];
                  lo <= prod[N-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table, scoreboard on done,
// plus hand sequences for latency, interlock and reset abort.
module tb_muldiv_unit;

   localparam int N = 32;

   logic         clk;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [N-1:0] x;
   logic [N-1:0] y;
   logic         wr_hi;
   logic         wr_lo;
   logic [N-1:0] wdata;
   logic         busy;
   logic         done;
   logic [N-1:0] hi;
   logic [N-1:0] lo;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] eh;
      logic [31:0] el;
   } vec_t;

   vec_t        tbl[$];
   logic [63:0] sb[$];
   int          checks = 0;
   int          errors = 0;

   muldiv_unit #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .x     (x),
      .y     (y),
      .wr_hi (wr_hi),
      .wr_lo (wr_lo),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   // Scoreboard: compare every completed operation
   always @(negedge clk) begin
      logic [63:0] e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done act=1 exp=0");
         end else begin
            e = sb.pop_front();
            chk("hi", hi, e[63:32]);
            chk("lo", lo, e[31:0]);
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh,
                        input logic [31:0] el);
      start = 1'b1;
      op    = o;
      x     = a;
      y     = b;
      sb.push_back({eh, el});
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || sb.size() != 0) && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL timeout act=busy exp=idle");
         sb.delete();
      end
   endtask

   initial begin
      int          n;
      logic        early;
      logic [31:0] h0;
      logic [31:0] l0;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  o;
      longint      sa;
      longint      sbv;
      logic [63:0] p;

      tbl.push_back('{2'b10, 32'hFFFFFFF9, 32'h2,
                      32'hFFFFFFFF, 32'hFFFFFFFD});
      tbl.push_back('{2'b11, 32'h7, 32'h2, 32'h1, 32'h3});
      tbl.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF,
                      32'h0, 32'h80000000});
      tbl.push_back('{2'b11, 32'h1234, 32'h0,
                      32'h1234, 32'hFFFFFFFF});
      tbl.push_back('{2'b10, 32'h1234, 32'h0,
                      32'h1234, 32'hFFFFFFFF});
      tbl.push_back('{2'b10, 32'hFFFFFFF9, 32'h0,
                      32'hFFFFFFF9, 32'hFFFFFFFF});
      tbl.push_back('{2'b10, 32'h7, 32'hFFFFFFFE,
                      32'h1, 32'hFFFFFFFD});
      tbl.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
                      32'h0, 32'h1});
      tbl.push_back('{2'b00, 32'h12345678, 32'hFFFFFFFF,
                      32'hFFFFFFFF, 32'hEDCBA988});
      tbl.push_back('{2'b11, 32'hFFFFFFFF, 32'h1,
                      32'h0, 32'hFFFFFFFF});

      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      x     = '0;
      y     = '0;
      wr_hi = 1'b0;
      wr_lo = 1'b0;
      wdata = '0;

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      #1;

      // MULTU max x max: busy length and result timing
      h0 = hi;
      l0 = lo;
      early = 1'b0;
      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFE, 32'h00000001);
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (busy && (hi !== h0 || lo !== l0)) early = 1'b1;
      end
      chk("busy_cycles", 32'(n), 32'd33);
      chk("early_write", 32'(early), 32'h0);
      chk("done_pulse", 32'(done), 32'h1);
      @(posedge clk);
      #1;
      chk("done_width", 32'(done), 32'h0);
      wait_idle();

      // MULT then back-to-back MULT issued in the done cycle
      issue(2'b00, 32'hFFFFFFF9, 32'h6, 32'hFFFFFFFF, 32'hFFFFFFD6);
      n = 0;
      while (!done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL b2b_timeout act=%0d exp=33", n);
      end
      issue(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
      chk("b2b_busy", 32'(busy), 32'h1);
      wait_idle();

      // Table of fixed vectors
      for (int i = 0; i < tbl.size(); i++) begin
         issue(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].eh, tbl[i].el);
         wait_idle();
      end

      // Random vectors against a wide-integer model
      for (int i = 0; i < 8; i++) begin
         a = $urandom;
         b = $urandom;
         if (b == 0) b = 32'h1;
         o = 2'(i % 4);
         if (o[0]) begin
            sa  = longint'({32'h0, a});
            sbv = longint'({32'h0, b});
         end else begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
         end
         if (o[1]) begin
            p[63:32] = 32'(sa % sbv);
            p[31:0]  = 32'(sa / sbv);
         end else begin
            p = 64'(sa * sbv);
         end
         issue(o, a, b, p[63:32], p[31:0]);
         wait_idle();
      end

      // Busy interlock: start and MTHI ignored mid-operation
      issue(2'b01, 32'h3, 32'h5, 32'h0, 32'hF);
      repeat (9) @(posedge clk);
      #1;
      h0    = hi;
      start = 1'b1;
      op    = 2'b11;
      x     = 32'd99;
      y     = 32'd3;
      wr_hi = 1'b1;
      wdata = 32'hAAAA;
      @(posedge clk);
      #1;
      start = 1'b0;
      wr_hi = 1'b0;
      chk("hi_locked", hi, h0);
      chk("still_busy", 32'(busy), 32'h1);
      wait_idle();
      repeat (40) @(negedge clk);

      // MTLO/MTHI when idle
      wr_lo = 1'b1;
      wdata = 32'h55;
      @(posedge clk);
      #1;
      wr_lo = 1'b0;
      chk("mtlo", lo, 32'h55);
      wr_hi = 1'b1;
      wdata = 32'h77;
      @(posedge clk);
      #1;
      wr_hi = 1'b0;
      chk("mthi", hi, 32'h77);
      chk("mthi_lo_kept", lo, 32'h55);

      // Reset abort in the middle of DIVU 100/7
      @(negedge clk);
      issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
      repeat (11) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_done", 32'(done), 32'h0);
      chk("abort_hi", hi, 32'h0);
      chk("abort_lo", lo, 32'h0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
      wait_idle();
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
